// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier system:
// the state encoding and the operand ROM initialisation rule.
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_MUL    = 3'd3,
    S_STORE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // ROM word i holds (i+1) modulo 2**w
  function automatic int unsigned rom_val(input int unsigned i, input int unsigned w);
    return (i + 1) % (32'd1 << w);
  endfunction

endpackage

// File: rtl/seq_mult_system_if.sv
// Control/data bundle between the board-level switches/LEDs and seq_mult_system.
interface seq_mult_system_if #(
  parameter int W      = 4,
  parameter int ROM_AW = 3,
  parameter int RAM_AW = 3
) ();

  // start is sampled only while busy is low; once accepted, busy stays high
  // until the operation ends, and done pulses for exactly one cycle before
  // busy drops. A start seen while busy is dropped, never queued.
  logic              start;
  logic [ROM_AW-1:0] adr1_r;
  logic [ROM_AW-1:0] adr2_r;
  logic [RAM_AW-1:0] adr_ram;
  logic [RAM_AW-1:0] rd_adr;
  logic [2*W-1:0]    result;
  logic              busy;
  logic              done;
  logic [2:0]        st_out;

  modport master (
    output start, adr1_r, adr2_r, adr_ram, rd_adr,
    input  result, busy, done, st_out
  );

  modport slave (
    input  start, adr1_r, adr2_r, adr_ram, rd_adr,
    output result, busy, done, st_out
  );

endinterface

// File: rtl/seq_mult_system_mult.sv
// W-cycle shift-add multiplier: load captures operands, go advances one bit
// per cycle, last flags the final step, product is exact and sign-corrected.
module shift_add_mult #(
  parameter int W      = 4,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           go,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic           last,
  output logic [2*W-1:0] product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]   mcand;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic [W:0]     sum;

  // Magnitudes fit in W unsigned bits, including the most negative value
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    if ((SIGNED != 0) && x[W-1]) return -x;
    return x;
  endfunction

  always_comb begin
    sum = {1'b0, acc[2*W-1:W]};
    if (acc[0]) sum = sum + {1'b0, mcand};
  end

  assign last    = (cnt == CW'(W - 1));
  assign product = neg ? -acc : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      ready <= 1'b1;
    end else if (load) begin
      // Upper half zeroed; multiplier sits in the lower half and shifts out
      mcand <= mag(a);
      acc   <= {{W{1'b0}}, mag(b)};
      cnt   <= '0;
      neg   <= (SIGNED != 0) && (a[W-1] ^ b[W-1]);
      ready <= 1'b0;
    end else if (go && !ready) begin
      acc <= {sum, acc[W-1:1]};
      cnt <= cnt + 1'b1;
      if (last) ready <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_mult_system.sv
// ROM -> register file -> shift-add multiplier -> result RAM, sequenced by a
// start/busy/done FSM; RAM read port is registered onto result.
module seq_mult_system
  import mult_pkg::*;
#(
  parameter int W      = 4,
  parameter int ROM_AW = 3,
  parameter int RAM_AW = 3,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_system_if.slave  bus
);

  state_t            state, nxt;
  logic [ROM_AW-1:0] adr1_q, adr2_q;
  logic [RAM_AW-1:0] ram_adr_q;
  logic [W-1:0]      rf [2];
  logic [2*W-1:0]    ram [2**RAM_AW];
  logic [2*W-1:0]    result_q;
  logic [W-1:0]      rom_a, rom_b;
  logic              eng_load, eng_go, eng_ready, eng_last;
  logic [2*W-1:0]    eng_product;
  logic              ram_we;

  always_comb begin
    rom_a = W'(rom_val(32'(adr1_q), W));
    rom_b = W'(rom_val(32'(adr2_q), W));
  end

  // Operand B goes to the engine straight from the ROM while RF[1] captures it
  shift_add_mult #(.W(W), .SIGNED(SIGNED)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (eng_load),
    .go      (eng_go),
    .a       (rf[0]),
    .b       (rom_b),
    .ready   (eng_ready),
    .last    (eng_last),
    .product (eng_product)
  );

  always_comb begin
    nxt      = state;
    eng_load = 1'b0;
    eng_go   = 1'b0;
    ram_we   = 1'b0;
    case (state)
      S_IDLE:   if (bus.start) nxt = S_LOAD_A;
      S_LOAD_A: nxt = S_LOAD_B;
      S_LOAD_B: begin
        eng_load = 1'b1;
        nxt      = S_MUL;
      end
      S_MUL: begin
        eng_go = 1'b1;
        if (eng_last) nxt = S_STORE;
      end
      S_STORE: begin
        ram_we = eng_ready;
        nxt    = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr1_q    <= '0;
      adr2_q    <= '0;
      ram_adr_q <= '0;
      rf[0]     <= '0;
      rf[1]     <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        adr1_q    <= bus.adr1_r;
        adr2_q    <= bus.adr2_r;
        ram_adr_q <= bus.adr_ram;
      end
      if (state == S_LOAD_A) rf[0] <= rom_a;
      if (state == S_LOAD_B) rf[1] <= rom_b;
    end
  end

  // Read port samples the pre-write contents when it hits the STORE address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**RAM_AW; i++) ram[i] <= '0;
      result_q <= '0;
    end else begin
      result_q <= ram[bus.rd_adr];
      if (ram_we) ram[ram_adr_q] <= eng_product;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.st_out = state;

endmodule

// File: tb/tb_seq_mult_system.sv
// Drives an unsigned and a signed seq_mult_system with identical stimulus and
// checks both against an arithmetic reference of ROM contents and RAM state.
module tb_seq_mult_system;

  localparam int W      = 4;
  localparam int ROM_AW = 3;
  localparam int RAM_AW = 3;
  localparam int PW     = 2 * W;
  localparam int DEPTH  = 2**RAM_AW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mult_system_if #(.W(W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) u_bus ();
  seq_mult_system_if #(.W(W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) s_bus ();

  seq_mult_system #(.W(W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .SIGNED(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  seq_mult_system #(.W(W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .SIGNED(1)) s_dut (
    .clk (clk),
    .rst (rst),
    .bus (s_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] ram_u [DEPTH];
  logic [PW-1:0] ram_s [DEPTH];
  logic [PW-1:0] exp_q [$];
  int            walk  [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ROM word is (i+1) mod 2**W, read as two's complement when signed
  function automatic logic [PW-1:0] ref_prod(input int ai, input int bi, input bit sgn);
    int a, b;
    a = (ai + 1) % (1 << W);
    b = (bi + 1) % (1 << W);
    if (sgn && a >= (1 << (W - 1))) a -= (1 << W);
    if (sgn && b >= (1 << (W - 1))) b -= (1 << W);
    return PW'(a * b);
  endfunction

  task automatic drive(input logic st, input int a, input int b, input int ra, input int rd);
    u_bus.start   = st;              s_bus.start   = st;
    u_bus.adr1_r  = ROM_AW'(a);      s_bus.adr1_r  = ROM_AW'(a);
    u_bus.adr2_r  = ROM_AW'(b);      s_bus.adr2_r  = ROM_AW'(b);
    u_bus.adr_ram = RAM_AW'(ra);     s_bus.adr_ram = RAM_AW'(ra);
    u_bus.rd_adr  = RAM_AW'(rd);     s_bus.rd_adr  = RAM_AW'(rd);
  endtask

  task automatic set_start(input logic st);
    u_bus.start = st;
    s_bus.start = st;
  endtask

  task automatic check_outputs(input string tag, input int st, input logic [PW-1:0] eu,
                               input logic [PW-1:0] es);
    check({tag, "_st_u"},   16'(u_bus.st_out), 16'(st));
    check({tag, "_st_s"},   16'(s_bus.st_out), 16'(st));
    check({tag, "_busy_u"}, 16'(u_bus.busy),   16'(st != 0));
    check({tag, "_busy_s"}, 16'(s_bus.busy),   16'(st != 0));
    check({tag, "_done_u"}, 16'(u_bus.done),   16'(st == 5));
    check({tag, "_done_s"}, 16'(s_bus.done),   16'(st == 5));
    check({tag, "_res_u"},  16'(u_bus.result), 16'(eu));
    check({tag, "_res_s"},  16'(s_bus.result), 16'(es));
  endtask

  // One operation from an idle, start-low system; optionally a stray start
  // with altered addresses is raised mid-multiply and must have no effect.
  task automatic run_op(input string tag, input int a, input int b, input int ra,
                        input int rd, input bit disturb);
    logic [PW-1:0] pu, ps, eu, es;
    pu = ref_prod(a, b, 1'b0);
    ps = ref_prod(a, b, 1'b1);
    drive(1'b1, a, b, ra, rd);
    for (int i = 0; i < walk.size(); i++) begin
      @(negedge clk);
      eu = ram_u[rd];
      es = ram_s[rd];
      if (walk[i] == 5) begin
        ram_u[ra] = pu;
        ram_s[ra] = ps;
      end
      check_outputs(tag, walk[i], eu, es);
      if (i == 0) set_start(1'b0);
      if (disturb && i == 3) begin
        set_start(1'b1);
        u_bus.adr1_r  = ROM_AW'(a + 3);  s_bus.adr1_r  = ROM_AW'(a + 3);
        u_bus.adr_ram = RAM_AW'(ra + 1); s_bus.adr_ram = RAM_AW'(ra + 1);
      end
      if (disturb && i == 4) set_start(1'b0);
    end
    exp_q.push_back(pu);
    exp_q.push_back(ps);
  endtask

  task automatic pop_check(input string tag, input int ra);
    logic [PW-1:0] eu, es;
    u_bus.rd_adr = RAM_AW'(ra);
    s_bus.rd_adr = RAM_AW'(ra);
    @(negedge clk);
    eu = exp_q.pop_front();
    es = exp_q.pop_front();
    check({tag, "_rb_u"}, 16'(u_bus.result), 16'(eu));
    check({tag, "_rb_s"}, 16'(s_bus.result), 16'(es));
  endtask

  task automatic read_check(input string tag, input int ra);
    u_bus.rd_adr = RAM_AW'(ra);
    s_bus.rd_adr = RAM_AW'(ra);
    @(negedge clk);
    check({tag, "_u"}, 16'(u_bus.result), 16'(ram_u[ra]));
    check({tag, "_s"}, 16'(s_bus.result), 16'(ram_s[ra]));
  endtask

  initial begin
    int done_cnt;
    logic prev_done;
    int guard;
    int ra, a, b, rd;

    // Expected state walk: LOAD_A, LOAD_B, W x MUL, STORE, DONE, IDLE
    walk.push_back(1);
    walk.push_back(2);
    for (int i = 0; i < W; i++) walk.push_back(3);
    walk.push_back(4);
    walk.push_back(5);
    walk.push_back(0);
    for (int i = 0; i < DEPTH; i++) begin
      ram_u[i] = '0;
      ram_s[i] = '0;
    end

    // Power-on reset
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    #2;
    check_outputs("reset", 0, '0, '0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of MUL aborts without writing RAM
    drive(1'b1, 2, 4, 6, 0);
    @(negedge clk);
    set_start(1'b0);
    repeat (4) @(negedge clk);
    check("midmul_state_u", 16'(u_bus.st_out), 16'd3);
    #2 rst = 1'b1;
    #1;
    check_outputs("abort", 0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    read_check("abort_ram6", 6);

    // Directed unsigned/signed products
    run_op("op_2x4", 2, 4, 3, 3, 1'b0);
    pop_check("op_2x4", 3);
    check("lit_15", 16'(u_bus.result), 16'h0F);

    run_op("op_7x7", 7, 7, 4, 4, 1'b0);
    pop_check("op_7x7", 4);
    check("lit_64_u", 16'(u_bus.result), 16'h40);
    check("lit_64_s", 16'(s_bus.result), 16'h40);

    run_op("op_7x0", 7, 0, 5, 5, 1'b0);
    pop_check("op_7x0", 5);
    check("lit_8", 16'(u_bus.result), 16'h08);
    read_check("ram3_kept", 3);

    run_op("op_7x1", 7, 1, 6, 6, 1'b0);
    pop_check("op_7x1", 6);
    check("lit_f0", 16'(s_bus.result), 16'hF0);

    // Read-before-write on a fresh location
    run_op("rbw", 3, 5, 2, 2, 1'b0);
    pop_check("rbw", 2);

    // Stray start with changed addresses mid-multiply
    run_op("stray", 2, 3, 7, 7, 1'b1);
    pop_check("stray", 7);
    read_check("stray_ram0", 0);

    // Start held high: back-to-back operations, single-cycle done each
    drive(1'b1, 1, 2, 1, 0);
    done_cnt  = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (u_bus.done) done_cnt++;
      check("done_width", 16'(prev_done & u_bus.done), 16'd0);
      prev_done = u_bus.done;
    end
    check("held_ops", 16'(done_cnt), 16'd3);
    set_start(1'b0);
    guard = 0;
    while (u_bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("held_drain", 16'(u_bus.busy), 16'd0);
    ram_u[1] = ref_prod(1, 2, 1'b0);
    ram_s[1] = ref_prod(1, 2, 1'b1);
    read_check("held_ram1", 1);

    // Randomised operations
    for (int n = 0; n < 16; n++) begin
      a  = $urandom_range(0, 7);
      b  = $urandom_range(0, 7);
      ra = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      run_op("rnd", a, b, ra, rd, 1'($urandom_range(0, 1)));
      pop_check("rnd", ra);
    end
    for (int i = 0; i < DEPTH; i++) read_check("final_ram", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
